// File: rtl/parking_gate_controller.sv
// Entry-gate sequencer for an 8-spot lot: allocates the lowest free spot, commits it on gate_clear.
// Optional feature macro: PARK_STATS_EN adds saturating entry/reject counters.
module parking_gate_controller #(
    parameter int unsigned NUM_SPOTS    = 8,
    parameter int unsigned GATE_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_entry,
    input  logic        i_gate_clear,
    input  logic        i_exit,
    input  logic [2:0]  i_exit_spot,
    output logic [2:0]  o_park_number,
    output logic        o_park_valid,
    output logic        o_gate_open,
    output logic [7:0]  o_parking_capacity,
    output logic [3:0]  o_occupied_count,
    output logic        o_full,
    output logic        o_full_reject,
    output logic        o_gate_timeout,
    output logic        o_exit_err
`ifdef PARK_STATS_EN
    ,
    output logic [15:0] o_total_entries,
    output logic [15:0] o_total_rejects
`endif
);

    localparam int unsigned TW = $clog2(GATE_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StOpen, StClose} state_e;

    state_e          r_state, w_state_next;
    logic [TW-1:0]   r_timer, w_timer_next;
    logic [7:0]      r_cap, w_cap_next;
    logic [3:0]      r_count, w_count_next;
    logic [2:0]      r_park_number, w_park_number_next;
    logic            r_park_valid, w_park_valid_next;
    logic            r_gate_open, w_gate_open_next;
    logic            r_full_reject, w_full_reject_next;
    logic            r_gate_timeout, w_gate_timeout_next;
    logic            r_exit_err, w_exit_err_next;
    logic            w_full, w_commit, w_exit_ok;
    logic [2:0]      w_free_idx;

    assign w_full = (r_count == 4'(NUM_SPOTS));

    always_comb begin
        w_free_idx = 3'd0;
        for (int i = int'(NUM_SPOTS) - 1; i >= 0; i--) begin
            if (r_cap[i]) w_free_idx = 3'(i);
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_timer_next        = r_timer;
        w_park_number_next  = r_park_number;
        w_park_valid_next   = r_park_valid;
        w_gate_open_next    = r_gate_open;
        w_full_reject_next  = 1'b0;
        w_gate_timeout_next = 1'b0;
        w_commit            = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_entry) begin
                    if (w_full) begin
                        w_full_reject_next = 1'b1;
                    end else begin
                        w_state_next       = StOpen;
                        w_park_number_next = w_free_idx;
                        w_park_valid_next  = 1'b1;
                        w_gate_open_next   = 1'b1;
                        w_timer_next       = '0;
                    end
                end
            end
            StOpen: begin
                // gate_clear takes priority over an expiring timer
                if (i_gate_clear) begin
                    w_commit          = 1'b1;
                    w_park_valid_next = 1'b0;
                    w_gate_open_next  = 1'b0;
                    w_state_next      = StClose;
                end else if (r_timer == TW'(GATE_TIMEOUT - 1)) begin
                    w_gate_timeout_next = 1'b1;
                    w_park_valid_next   = 1'b0;
                    w_gate_open_next    = 1'b0;
                    w_state_next        = StClose;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            StClose: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Exit on a free spot (including the still-unreserved pending spot) is an error.
    assign w_exit_ok       = i_exit && !r_cap[i_exit_spot];
    assign w_exit_err_next = i_exit && r_cap[i_exit_spot];

    always_comb begin
        w_cap_next = r_cap;
        if (w_commit)  w_cap_next[r_park_number] = 1'b0;
        if (w_exit_ok) w_cap_next[i_exit_spot]   = 1'b1;
        case ({w_commit, w_exit_ok})
            2'b10:   w_count_next = r_count + 4'd1;
            2'b01:   w_count_next = r_count - 4'd1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_timer        <= '0;
            r_cap          <= 8'hFF;
            r_count        <= 4'd0;
            r_park_number  <= 3'd0;
            r_park_valid   <= 1'b0;
            r_gate_open    <= 1'b0;
            r_full_reject  <= 1'b0;
            r_gate_timeout <= 1'b0;
            r_exit_err     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_timer        <= w_timer_next;
            r_cap          <= w_cap_next;
            r_count        <= w_count_next;
            r_park_number  <= w_park_number_next;
            r_park_valid   <= w_park_valid_next;
            r_gate_open    <= w_gate_open_next;
            r_full_reject  <= w_full_reject_next;
            r_gate_timeout <= w_gate_timeout_next;
            r_exit_err     <= w_exit_err_next;
        end
    end

`ifdef PARK_STATS_EN
    logic [15:0] r_total_entries, r_total_rejects;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_total_entries <= 16'd0;
            r_total_rejects <= 16'd0;
        end else begin
            if (w_commit && r_total_entries != 16'hFFFF)
                r_total_entries <= r_total_entries + 16'd1;
            if (w_full_reject_next && r_total_rejects != 16'hFFFF)
                r_total_rejects <= r_total_rejects + 16'd1;
        end
    end

    assign o_total_entries = r_total_entries;
    assign o_total_rejects = r_total_rejects;
`endif

    assign o_park_number      = r_park_number;
    assign o_park_valid       = r_park_valid;
    assign o_gate_open        = r_gate_open;
    assign o_parking_capacity = r_cap;
    assign o_occupied_count   = r_count;
    assign o_full             = w_full;
    assign o_full_reject      = r_full_reject;
    assign o_gate_timeout     = r_gate_timeout;
    assign o_exit_err         = r_exit_err;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Self-checking bench for parking_gate_controller; spot assignments checked via a scoreboard queue.
module tb_parking_gate_controller;

    localparam int unsigned GATE_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst, entry, gate_clear, exit_p;
    logic [2:0]  exit_spot;
    logic [2:0]  o_park_number;
    logic        o_park_valid, o_gate_open, o_full, o_full_reject, o_gate_timeout, o_exit_err;
    logic [7:0]  o_parking_capacity;
    logic [3:0]  o_occupied_count;
`ifdef PARK_STATS_EN
    logic [15:0] o_total_entries, o_total_rejects;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q[$];
    logic        prev_valid = 1'b0;

    parking_gate_controller #(
        .NUM_SPOTS   (8),
        .GATE_TIMEOUT(GATE_TIMEOUT)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_entry           (entry),
        .i_gate_clear      (gate_clear),
        .i_exit            (exit_p),
        .i_exit_spot       (exit_spot),
        .o_park_number     (o_park_number),
        .o_park_valid      (o_park_valid),
        .o_gate_open       (o_gate_open),
        .o_parking_capacity(o_parking_capacity),
        .o_occupied_count  (o_occupied_count),
        .o_full            (o_full),
        .o_full_reject     (o_full_reject),
        .o_gate_timeout    (o_gate_timeout),
        .o_exit_err        (o_exit_err)
`ifdef PARK_STATS_EN
        ,
        .o_total_entries   (o_total_entries),
        .o_total_rejects   (o_total_rejects)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pop: each new assignment must match the oldest expected spot.
    always @(negedge clk) begin
        if (o_park_valid === 1'b1 && prev_valid === 1'b0) begin
            check_eq("sb_depth", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("park_number", 32'(o_park_number), exp_q.pop_front());
        end
        prev_valid = o_park_valid;
    end

    task automatic park_car(input logic [2:0] spot);
        exp_q.push_back(32'(spot));
        entry = 1'b1;
        step();
        entry = 1'b0;
        check_eq("gate_open_up", 32'(o_gate_open), 32'd1);
        step();
        step();
        gate_clear = 1'b1;
        step();
        gate_clear = 1'b0;
        check_eq("gate_closed", 32'(o_gate_open), 32'd0);
        step();
    endtask

    task automatic do_exit(input logic [2:0] spot);
        exit_p    = 1'b1;
        exit_spot = spot;
        step();
        exit_p    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst = 1'b1; entry = 1'b0; gate_clear = 1'b0; exit_p = 1'b0; exit_spot = 3'd0;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_cap", 32'(o_parking_capacity), 32'hFF);
        check_eq("rst_count", 32'(o_occupied_count), 32'd0);
        check_eq("rst_gate", 32'(o_gate_open), 32'd0);
        check_eq("rst_valid", 32'(o_park_valid), 32'd0);
        check_eq("rst_full", 32'(o_full), 32'd0);
        check_eq("rst_pnum", 32'(o_park_number), 32'd0);

        // gate_clear outside OPEN has no effect
        gate_clear = 1'b1;
        step();
        gate_clear = 1'b0;
        check_eq("stray_clear", 32'(o_parking_capacity), 32'hFF);

        for (int i = 0; i < 8; i++) park_car(3'(i));
        check_eq("fill_cap", 32'(o_parking_capacity), 32'h00);
        check_eq("fill_count", 32'(o_occupied_count), 32'd8);
        check_eq("fill_full", 32'(o_full), 32'd1);

        // Entry held high while full rejects every cycle
        entry = 1'b1;
        step();
        check_eq("reject1", 32'(o_full_reject), 32'd1);
        check_eq("reject_gate", 32'(o_gate_open), 32'd0);
        step();
        entry = 1'b0;
        check_eq("reject2", 32'(o_full_reject), 32'd1);
        step();
        check_eq("reject_end", 32'(o_full_reject), 32'd0);
`ifdef PARK_STATS_EN
        check_eq("stat_rej", 32'(o_total_rejects), 32'd2);
`endif

        do_exit(3'd5);
        check_eq("exit_cap", 32'(o_parking_capacity), 32'h20);
        check_eq("exit_count", 32'(o_occupied_count), 32'd7);
        check_eq("exit_noerr", 32'(o_exit_err), 32'd0);
        park_car(3'd5);
        check_eq("reuse_cap", 32'(o_parking_capacity), 32'h00);
`ifdef PARK_STATS_EN
        check_eq("stat_ent", 32'(o_total_entries), 32'd9);
`endif

        do_exit(3'd5);
        exp_q.push_back(32'd5);
        entry = 1'b1;
        step();
        entry = 1'b0;
        k = 1;
        while (o_gate_timeout !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        check_eq("timeout_lat", 32'(k), 32'(GATE_TIMEOUT + 1));
        check_eq("timeout_cap", 32'(o_parking_capacity), 32'h20);
        check_eq("timeout_gate", 32'(o_gate_open), 32'd0);
        step();
        check_eq("timeout_pulse", 32'(o_gate_timeout), 32'd0);

        do_exit(3'd2);
        check_eq("exit2_cap", 32'(o_parking_capacity), 32'h24);
        check_eq("exit2_count", 32'(o_occupied_count), 32'd6);
        do_exit(3'd2);
        check_eq("exit_err", 32'(o_exit_err), 32'd1);
        check_eq("err_count", 32'(o_occupied_count), 32'd6);
        step();
        check_eq("err_pulse", 32'(o_exit_err), 32'd0);

        // Reset while OPEN drops the reservation
        exp_q.push_back(32'd2);
        entry = 1'b1;
        step();
        entry = 1'b0;
        check_eq("open_b4_rst", 32'(o_gate_open), 32'd1);
        gate_clear = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        gate_clear = 1'b0;
        check_eq("mid_rst_gate", 32'(o_gate_open), 32'd0);
        check_eq("mid_rst_cap", 32'(o_parking_capacity), 32'hFF);
        check_eq("mid_rst_count", 32'(o_occupied_count), 32'd0);
        step();
        check_eq("no_commit", 32'(o_parking_capacity), 32'hFF);

        for (int i = 0; i < 4; i++) park_car(3'(i));
        exp_q.push_back(32'd4);
        entry = 1'b1;
        step();
        entry = 1'b0;
        step();
        gate_clear = 1'b1;
        exit_p     = 1'b1;
        exit_spot  = 3'd1;
        step();
        gate_clear = 1'b0;
        exit_p     = 1'b0;
        check_eq("both_cap", 32'(o_parking_capacity), 32'hE2);
        check_eq("both_count", 32'(o_occupied_count), 32'd4);
        check_eq("both_noerr", 32'(o_exit_err), 32'd0);
        step();
`ifdef PARK_STATS_EN
        check_eq("stat_ent2", 32'(o_total_entries), 32'd5);
`endif
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
